nec_divide_unit: RTL
====================

# nec_divide_unit

Parametrised iterative signed/unsigned divider for the NEC Vxx execution unit, successor to the fixed 32/16 divider. Supports configurable quotient width, multiple quotient bits per cycle, explicit signed/unsigned mode, and abort. It sits beside the ALU and serves DIV/DIVU, including the byte forms, under microcode control.

## Interface
Parameters:
- `W`, 16: quotient/divisor/remainder width in wide mode; even, ≥8.
- `STEP`, 1: quotient bits retired per iteration cycle; 1, 2 or 4; `W/2` must be divisible by `STEP`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; no state other than reset changes when low.
- `start`  in  1  request; accepted on a `ce` edge when `busy`=0.
- `abort`  in  1  cancels an in-flight operation.
- `wide`  in  1  1: `2W`/`W` division; 0: `W`/`W/2` division.
- `signed_op`  in  1  1: two's-complement operands; 0: unsigned.
- `a`  in  2W  dividend; narrow mode uses `a[W-1:0]`.
- `b`  in  W  divisor; narrow mode uses `b[W/2-1:0]`.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-`ce`-cycle completion pulse.
- `overflow`  out  1  quotient not representable; valid with `done`.
- `dbz`  out  1  divisor zero; valid with `done`.
- `quot`  out  W  quotient; narrow result in low `W/2` bits, upper bits zero.
- `rem`  out  W  remainder; same width rule as `quot`.

## Operation
- N = `W` (wide) or `W/2` (narrow). Operands are sampled at the start edge and held internally; `a`/`b` may change afterwards.
- Signed: magnitudes are taken at N+1/2N+1 bits, so the most-negative values are exact. Quotient truncates toward zero. Remainder takes the sign of the dividend. Quotient is negated when the operand signs differ.
- Restoring division, `STEP` bits per cycle. States: IDLE, RUN, FINISH.
- IDLE→RUN on an accepted start with nonzero divisor. IDLE→FINISH with `dbz`=1 when the divisor is zero.
- RUN runs K iterations, then goes to FINISH. FINISH registers the results, pulses `done` and returns to IDLE.
- Overflow when set:
  - unsigned: quotient > 2^N−1;
  - signed, positive result: magnitude > 2^(N−1)−1;
  - signed, negative result: magnitude > 2^(N−1).
- When `overflow` or `dbz` is set, `quot`/`rem` keep their previous values. Otherwise both update at `done`.
- `start` while `busy` is ignored.
- `abort` (with `ce`) in RUN/FINISH → IDLE. No `done`; outputs unchanged. `abort` has priority over `start` in the same cycle.
- `reset` at any time clears the state to IDLE and all outputs to 0. An operation interrupted by reset is lost.

## Timing
- Edges are counted in `ce`-qualified edges; edge 0 accepts `start`.
- `busy` is 1 from edge 0 to edge K+1, where it falls together with the rise of `done`.
- The iterations occupy edges 1..K. Results and `done` are registered at edge K+1.
- Divide by zero: `done`=`dbz`=1 at edge 1; `busy` is never asserted.
- A new `start` may be accepted on the edge after the `done` edge, i.e. while `done` is high.
- Reset values: `busy`=0, `done`=0, `overflow`=0, `dbz`=0, `quot`=0, `rem`=0.

## Configuration
- `NEC_DIV_EARLY_OVF_EN` defined:
  - Unsigned magnitude overflow is checked at edge 0: high N bits of |dividend| ≥ |divisor|.
  - If the check fires: `done`+`overflow` at edge 1.
  - Otherwise RUN starts with the high half preloaded, K = N/STEP.
  - The signed range check is still applied at FINISH.
- Not defined:
  - K = 2N/STEP. All dividend bits are iterated and the upper N quotient bits are inspected at FINISH.
- Results and flags are identical in both builds; only latency differs.

## Test plan
All cases W=16, STEP=1, macro off unless stated.
- Wide unsigned: a=0x0001_0000, b=0x0002 → quot=0x8000, rem=0, overflow=0. `done` at edge 33; with macro, edge 17.
- Wide signed: a=0xFFFF_FFF9 (−7), b=0x0002 → quot=0xFFFD, rem=0xFFFF. Second case: a=0xFFFF_8000, b=0x0001 → quot=0x8000, no overflow.
- Signed overflow: a=0x0000_8000, b=0x0001 → overflow=1, quot/rem equal to the prior result.
- Unsigned early overflow: a=0x0002_0000, b=0x0002 → overflow=1 at edge 1 with the macro, edge 33 without.
- Narrow: a=0x0064, b=0x0007, unsigned → quot=0x000E, rem=0x0002 at edge 17. Divide by zero: b=0 → `dbz`=1 at edge 1, `busy` stays 0.
- Abort:
  - abort at edge 5 → no `done`, outputs unchanged; a new start on the next edge completes normally.
  - `start` at edge 10 while busy is ignored.
  - async `reset` mid-RUN → all outputs 0 immediately.
- STEP=4 regression: randomised operands against a reference model → results identical to STEP=1; `done` at edge 9 wide (macro off).

Source files
------------

// File: rtl/nec_divide_unit_if.sv
// Request/result bundle for nec_divide_unit: operands and mode in, status and results out.
// The clock and reset stay plain ports on the divider itself.
interface nec_divide_unit_if #(
  parameter int W = 16
);
  logic           ce;
  logic           start;
  logic           abort;
  logic           wide;
  logic           signed_op;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic           overflow;
  logic           dbz;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  modport master (
    output ce, start, abort, wide, signed_op, a, b,
    input  busy, done, overflow, dbz, quot, rem
  );

  modport slave (
    input  ce, start, abort, wide, signed_op, a, b,
    output busy, done, overflow, dbz, quot, rem
  );
endinterface

// File: rtl/nec_divide_unit.sv
// Iterative restoring signed/unsigned divider (2W/W wide, W/W/2 narrow), STEP quotient bits per cycle.
// Optional build macro NEC_DIV_EARLY_OVF_EN: reject unsigned overflow up front and iterate only N bits.
module nec_divide_unit #(
  parameter int W    = 16,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  nec_divide_unit_if.slave bus
);
  localparam int CW = $clog2(2*W/STEP + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t         r_state, w_state_next;
  logic [W-1:0]   r_rem, r_div, r_quot, r_rem_out;
  logic [2*W-1:0] r_dvd;
  logic [CW-1:0]  r_cnt;
  logic           r_wide, r_sgn, r_q_neg, r_r_neg, r_dbz_pend, r_ovf_pend;
  logic           r_busy, r_done, r_ovf, r_dbz;

  logic           w_a_neg, w_b_neg, w_b_zero, w_early_ovf, w_accept, w_fin_ovf;
  logic [2*W-1:0] w_a_mag, w_dvd_init, w_dvd_step, w_umax, w_slim;
  logic [W-1:0]   w_b_mag, w_rem_init, w_rem_step;
  logic [W-1:0]   w_q_sgn, w_r_sgn, w_quot_res, w_rem_res;
  logic [CW-1:0]  w_k;

  assign w_accept = bus.start & ~bus.abort;

  // Magnitudes at full operand width so the most-negative value stays exact.
  always_comb begin
    w_a_neg = bus.signed_op & (bus.wide ? bus.a[2*W-1] : bus.a[W-1]);
    w_b_neg = bus.signed_op & (bus.wide ? bus.b[W-1] : bus.b[W/2-1]);
    if (bus.wide) begin
      w_a_mag = w_a_neg ? -bus.a : bus.a;
      w_b_mag = w_b_neg ? -bus.b : bus.b;
    end else begin
      w_a_mag = {{W{1'b0}}, (w_a_neg ? -bus.a[W-1:0] : bus.a[W-1:0])};
      w_b_mag = {{(W/2){1'b0}}, (w_b_neg ? -bus.b[W/2-1:0] : bus.b[W/2-1:0])};
    end
    w_b_zero = (w_b_mag == '0);
  end

`ifdef NEC_DIV_EARLY_OVF_EN
  logic [W-1:0] w_a_hi;

  always_comb begin
    w_a_hi      = bus.wide ? w_a_mag[2*W-1:W] : {{(W/2){1'b0}}, w_a_mag[W-1:W/2]};
    w_early_ovf = (w_a_hi >= w_b_mag);
    w_k         = bus.wide ? CW'(W/STEP) : CW'(W/2/STEP);
    w_rem_init  = w_a_hi;
    w_dvd_init  = bus.wide ? {w_a_mag[W-1:0], {W{1'b0}}}
                           : {w_a_mag[W/2-1:0], {(3*W/2){1'b0}}};
  end
`else
  always_comb begin
    w_early_ovf = 1'b0;
    w_k         = bus.wide ? CW'(2*W/STEP) : CW'(W/STEP);
    w_rem_init  = '0;
    w_dvd_init  = bus.wide ? w_a_mag : {w_a_mag[W-1:0], {W{1'b0}}};
  end
`endif

  // Quotient bits enter r_dvd from the bottom as dividend bits leave the top.
  always_comb begin : p_iter
    logic [W:0]   v_shift;
    logic [W+1:0] v_diff;
    v_shift    = '0;
    v_diff     = '0;
    w_rem_step = r_rem;
    w_dvd_step = r_dvd;
    for (int i = 0; i < STEP; i++) begin
      v_shift    = {w_rem_step, w_dvd_step[2*W-1]};
      v_diff     = {1'b0, v_shift} - {2'b00, r_div};
      w_rem_step = v_diff[W+1] ? v_shift[W-1:0] : v_diff[W-1:0];
      w_dvd_step = {w_dvd_step[2*W-2:0], ~v_diff[W+1]};
    end
  end

  always_comb begin
    w_umax     = r_wide ? {{W{1'b0}}, {W{1'b1}}} : {{(3*W/2){1'b0}}, {(W/2){1'b1}}};
    w_slim     = r_wide ? {{(W+1){1'b0}}, 1'b1, {(W-1){1'b0}}}
                        : {{(3*W/2+1){1'b0}}, 1'b1, {(W/2-1){1'b0}}};
    if (!r_sgn)       w_fin_ovf = (r_dvd > w_umax);
    else if (r_q_neg) w_fin_ovf = (r_dvd > w_slim);
    else              w_fin_ovf = (r_dvd >= w_slim);
    w_q_sgn    = r_q_neg ? -r_dvd[W-1:0] : r_dvd[W-1:0];
    w_r_sgn    = r_r_neg ? -r_rem : r_rem;
    w_quot_res = r_wide ? w_q_sgn : {{(W/2){1'b0}}, w_q_sgn[W/2-1:0]};
    w_rem_res  = r_wide ? w_r_sgn : {{(W/2){1'b0}}, w_r_sgn[W/2-1:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.ce && w_accept)
          w_state_next = (w_b_zero || w_early_ovf) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        if (bus.ce) begin
          if (bus.abort)               w_state_next = S_IDLE;
          else if (r_cnt == CW'(1))    w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        if (bus.ce) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0; r_div <= '0; r_dvd <= '0; r_cnt <= '0;
      r_wide <= 1'b0; r_sgn <= 1'b0; r_q_neg <= 1'b0; r_r_neg <= 1'b0;
      r_dbz_pend <= 1'b0; r_ovf_pend <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0; r_ovf <= 1'b0; r_dbz <= 1'b0;
      r_quot <= '0; r_rem_out <= '0;
    end else if (bus.ce) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem      <= w_rem_init;
            r_dvd      <= w_dvd_init;
            r_div      <= w_b_mag;
            r_cnt      <= w_k;
            r_wide     <= bus.wide;
            r_sgn      <= bus.signed_op;
            r_q_neg    <= w_a_neg ^ w_b_neg;
            r_r_neg    <= w_a_neg;
            r_dbz_pend <= w_b_zero;
            r_ovf_pend <= ~w_b_zero & w_early_ovf;
            r_busy     <= ~w_b_zero;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_busy <= 1'b0;
          end else begin
            r_rem <= w_rem_step;
            r_dvd <= w_dvd_step;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FINISH: begin
          r_busy <= 1'b0;
          if (!bus.abort) begin
            r_done <= 1'b1;
            r_dbz  <= r_dbz_pend;
            r_ovf  <= ~r_dbz_pend & (r_ovf_pend | w_fin_ovf);
            // Error results leave the previous quotient/remainder visible.
            if (!r_dbz_pend && !r_ovf_pend && !w_fin_ovf) begin
              r_quot    <= w_quot_res;
              r_rem_out <= w_rem_res;
            end
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.dbz      = r_dbz;
  assign bus.quot     = r_quot;
  assign bus.rem      = r_rem_out;
endmodule
